// File: rtl/param_seven_seg_scan_driver_if.sv
// Display-side bundle for param_seven_seg_scan_driver.
//   master : drives the digit/dp/blanking/brightness requests, observes the panel pins
//   slave  : the scan driver; samples requests, drives anodes, cathodes, dp, frame_start
// Signals:
//   bcd_in      [4*NUM_DIGITS] BCD digits, digit 0 in the low nibble
//   dp_in       [NUM_DIGITS]   decimal point request per digit, 1 = lit
//   blank_lz                   leading-zero blanking enable
//   brightness  [BRIGHT_W]     PWM duty level, 0 = dark
//   seg_anode   [NUM_DIGITS]   digit enables, active-low
//   seg_cathode [7]            segments {g,f,e,d,c,b,a}, active-low
//   seg_dp                     decimal point segment, active-low
//   frame_start                one-cycle pulse when a new snapshot is taken
interface param_seven_seg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BRIGHT_W   = 4
);

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   seg_anode;
  logic [6:0]              seg_cathode;
  logic                    seg_dp;
  logic                    frame_start;

  modport master (
    output bcd_in, dp_in, blank_lz, brightness,
    input  seg_anode, seg_cathode, seg_dp, frame_start
  );

  modport slave (
    input  bcd_in, dp_in, blank_lz, brightness,
    output seg_anode, seg_cathode, seg_dp, frame_start
  );

endinterface

// File: rtl/param_seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with leading-zero blanking and PWM dimming.
// Each digit owns a slot of DIGIT_CYCLES clocks; the slot is divided into
// 2^BRIGHT_W sub-slots and the digit is lit only while sub-slot < brightness.
// Inputs are sampled into a snapshot once per frame so a frame never tears.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   io_disp  slave side of param_seven_seg_scan_driver_if (requests in, panel pins out)
// All panel outputs are registered; they show the state of the previous cycle.
module param_seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 1024,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  param_seven_seg_scan_driver_if.slave  io_disp
);

  localparam int unsigned SLOT_W    = $clog2(DIGIT_CYCLES);
  localparam int unsigned DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SUB_SHIFT = SLOT_W - BRIGHT_W;
  localparam int unsigned BCD_W     = 4 * NUM_DIGITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [6:0]        SEG_OFF    = 7'b1111111;
  localparam logic [6:0]        SEG_DASH   = 7'b0111111;

  // Frame snapshot of all display requests
  typedef struct packed {
    logic [BCD_W-1:0]      bcd;
    logic [NUM_DIGITS-1:0] dp;
    logic                  blank_lz;
    logic [BRIGHT_W-1:0]   bright;
  } snap_t;

  // LOAD: first cycle out of reset, snapshot pending; SCAN: normal multiplexing
  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SLOT_W-1:0]     r_slot;
  logic [DIG_W-1:0]      r_digit;
  snap_t                 r_snap;

  logic [NUM_DIGITS-1:0] r_anode;
  logic [6:0]            r_cathode;
  logic                  r_dp;
  logic                  r_frame_start;

  logic                  w_frame_wrap;
  logic                  w_capture;
  logic                  w_advance;
  logic [NUM_DIGITS-1:0] w_blank_vec;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [3:0]            w_cur_bcd;
  logic                  w_cur_dp;
  logic                  w_cur_blank;
  logic [BRIGHT_W-1:0]   w_sub;
  logic                  w_pwm_on;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_anode_nxt;
  logic [6:0]            w_cathode_nxt;
  logic                  w_dp_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [6:0] f_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Last slot of the last digit: the next edge starts a new frame
  assign w_frame_wrap = (r_slot == SLOT_LAST) && (r_digit == DIGIT_LAST);

  // Scan state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scan next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: w_state_nxt = ST_SCAN;
      ST_SCAN: w_state_nxt = ST_SCAN;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Scan control outputs: LOAD holds the counters at 0 while the first snapshot lands
  always_comb begin
    w_capture = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_LOAD: w_capture = 1'b1;
      ST_SCAN: begin
        w_advance = 1'b1;
        w_capture = w_frame_wrap;
      end
      default: w_capture = 1'b0;
    endcase
  end

  // Slot counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot  <= '0;
      r_digit <= '0;
    end else if (w_advance) begin
      if (r_slot == SLOT_LAST) begin
        r_slot  <= '0;
        r_digit <= (r_digit == DIGIT_LAST) ? '0 : r_digit + DIG_W'(1);
      end else begin
        r_slot <= r_slot + SLOT_W'(1);
      end
    end
  end

  // Frame snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
    end else if (w_capture) begin
      r_snap.bcd      <= io_disp.bcd_in;
      r_snap.dp       <= io_disp.dp_in;
      r_snap.blank_lz <= io_disp.blank_lz;
      r_snap.bright   <= io_disp.brightness;
    end
  end

  // Leading-zero mask: walk down from the top digit while everything seen is zero
  always_comb begin
    logic v_zero;
    v_zero      = 1'b1;
    w_blank_vec = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      v_zero = v_zero & (r_snap.bcd[4*i +: 4] == 4'd0);
      if (i != 0) begin
        w_blank_vec[i] = r_snap.blank_lz & v_zero;
      end
    end
  end

  // Current digit select
  always_comb begin
    w_cur_bcd   = '0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b0;
    w_sel       = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit == DIG_W'(i)) begin
        w_cur_bcd   = r_snap.bcd[4*i +: 4];
        w_cur_dp    = r_snap.dp[i];
        w_cur_blank = w_blank_vec[i];
        w_sel[i]    = 1'b1;
      end
    end
  end

  // PWM: upper bits of the slot counter are the sub-slot number
  assign w_sub    = BRIGHT_W'(r_slot >> SUB_SHIFT);
  assign w_pwm_on = (w_sub < r_snap.bright);
  assign w_lit    = w_pwm_on & ~w_cur_blank;

  // Panel pin values for the current cycle; a dark digit drives everything off
  always_comb begin
    w_anode_nxt   = '1;
    w_cathode_nxt = SEG_OFF;
    w_dp_nxt      = 1'b1;
    if (w_lit) begin
      w_anode_nxt   = ~w_sel;
      w_cathode_nxt = f_decode(w_cur_bcd);
      w_dp_nxt      = ~w_cur_dp;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anode       <= '1;
      r_cathode     <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_anode       <= w_anode_nxt;
      r_cathode     <= w_cathode_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_start <= w_capture;
    end
  end

  assign io_disp.seg_anode   = r_anode;
  assign io_disp.seg_cathode = r_cathode;
  assign io_disp.seg_dp      = r_dp;
  assign io_disp.frame_start = r_frame_start;

endmodule

// File: tb/tb_param_seven_seg_scan_driver.sv
// Scoreboard bench: each test pushes hand-built expected frames, a monitor
// pops one per frame_start and checks all 64 output cycles of that frame.
module tb_param_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int DC = 16;
  localparam int BW = 2;
  localparam int FRAME = ND * DC;

  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C6 = 7'b0000010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] CD = 7'b0111111;

  typedef struct packed {
    logic [27:0] cath;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [1:0]  bright;
  } frame_t;

  logic clk;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   checks = 0;
  int   errors = 0;
  frame_t exp_q[$];
  bit   active = 1'b0;

  param_seven_seg_scan_driver_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) dif ();

  param_seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BRIGHT_W(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_disp(dif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s c=%0d got=%0h exp=%0h t=%0t", name, c, got, exp, $time);
    end
  endtask

  function automatic frame_t mkf(input logic [6:0] c3, input logic [6:0] c2, input logic [6:0] c1,
                                 input logic [6:0] c0, input logic [3:0] dp, input logic [3:0] blank,
                                 input logic [1:0] br);
    frame_t f;
    f.cath   = {c3, c2, c1, c0};
    f.dp     = dp;
    f.blank  = blank;
    f.bright = br;
    return f;
  endfunction

  // Monitor: reset values while in reset, then per-cycle frame checks
  initial begin
    frame_t cur;
    int     c;
    logic   prev_rst_q;
    int     d, s;
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_ca;
    logic       e_dp;
    c = 0;
    prev_rst_q = 1'b1;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_anode", c, 32'(dif.seg_anode), 32'hF);
        chk("rst_cathode", c, 32'(dif.seg_cathode), 32'h7F);
        chk("rst_dp", c, 32'(dif.seg_dp), 32'h1);
        chk("rst_frame_start", c, 32'(dif.frame_start), 32'h0);
        active = 1'b0;
      end else begin
        if (prev_rst_q) chk("fs_after_rst", 0, 32'(dif.frame_start), 32'h1);
        if (active) begin
          d    = c / DC;
          s    = c % DC;
          lit  = ((s / 4) < int'(cur.bright)) && !cur.blank[d];
          e_an = 4'hF;
          if (lit) e_an[d] = 1'b0;
          e_ca = lit ? cur.cath[7*d +: 7] : 7'h7F;
          e_dp = (lit && cur.dp[d]) ? 1'b0 : 1'b1;
          chk("anode", c, 32'(dif.seg_anode), 32'(e_an));
          chk("cathode", c, 32'(dif.seg_cathode), 32'(e_ca));
          chk("dp", c, 32'(dif.seg_dp), 32'(e_dp));
          chk("frame_start", c, 32'(dif.frame_start), (c == FRAME - 1) ? 32'h1 : 32'h0);
          c++;
          if (c == FRAME) active = 1'b0;
        end
        if (dif.frame_start && exp_q.size() > 0) begin
          cur    = exp_q.pop_front();
          c      = 0;
          active = 1'b1;
        end
      end
      prev_rst_q = rst_q;
    end
  end

  // Assert reset with new inputs; returns once the DUT has sampled it
  task automatic begin_reset(input logic [15:0] bcd, input logic [3:0] dp, input logic blz, input logic [1:0] br);
    @(posedge clk);
    #2;
    rst            = 1'b1;
    dif.bcd_in     = bcd;
    dif.dp_in      = dp;
    dif.blank_lz   = blz;
    dif.brightness = br;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk);
      #1;
      if (dif.frame_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame_start got=timeout exp=pulse t=%0t", $time);
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 8 * FRAME && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !active) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d_pending exp=0 t=%0t", exp_q.size(), $time);
      exp_q.delete();
    end
  endtask

  initial begin
    dif.bcd_in     = '0;
    dif.dp_in      = '0;
    dif.blank_lz   = 1'b0;
    dif.brightness = '0;

    // Basic scan of 1234 at brightness 3, two consecutive frames
    begin_reset(16'h1234, 4'b0000, 1'b0, 2'd3);
    exp_q.push_back(mkf(C1, C2, C3, C4, 4'b0000, 4'b0000, 2'd3));
    exp_q.push_back(mkf(C1, C2, C3, C4, 4'b0000, 4'b0000, 2'd3));
    release_reset();
    wait_done();

    // Leading-zero blanking of 0070, then blanking disabled mid-frame
    begin_reset(16'h0070, 4'b0000, 1'b1, 2'd3);
    exp_q.push_back(mkf(C0, C0, C7, C0, 4'b0000, 4'b1100, 2'd3));
    exp_q.push_back(mkf(C0, C0, C7, C0, 4'b0000, 4'b0000, 2'd3));
    release_reset();
    wait_fs();
    repeat (20) @(posedge clk);
    #2 dif.blank_lz = 1'b0;
    wait_done();

    // Mid-frame input change is held off until the next snapshot
    begin_reset(16'h1234, 4'b0000, 1'b0, 2'd3);
    exp_q.push_back(mkf(C1, C2, C3, C4, 4'b0000, 4'b0000, 2'd3));
    exp_q.push_back(mkf(C5, C6, C7, C8, 4'b0000, 4'b0000, 2'd3));
    release_reset();
    wait_fs();
    repeat (20) @(posedge clk);
    #2 dif.bcd_in = 16'h5678;
    wait_done();

    // Brightness 0 (dark) then brightness 1 (4 of 16 cycles)
    begin_reset(16'h1234, 4'b0000, 1'b0, 2'd0);
    exp_q.push_back(mkf(C1, C2, C3, C4, 4'b0000, 4'b0000, 2'd0));
    exp_q.push_back(mkf(C1, C2, C3, C4, 4'b0000, 4'b0000, 2'd1));
    release_reset();
    wait_fs();
    repeat (20) @(posedge clk);
    #2 dif.brightness = 2'd1;
    wait_done();

    // Invalid BCD dashes with dp on digit 2, then brightness 2
    begin_reset(16'hAF09, 4'b0100, 1'b0, 2'd3);
    exp_q.push_back(mkf(CD, CD, C0, C9, 4'b0100, 4'b0000, 2'd3));
    exp_q.push_back(mkf(CD, CD, C0, C9, 4'b0100, 4'b0000, 2'd2));
    release_reset();
    wait_fs();
    repeat (20) @(posedge clk);
    #2 dif.brightness = 2'd2;
    wait_done();

    // All zeros with blanking: digit 0 stays, dp on a blanked digit is suppressed
    begin_reset(16'h0000, 4'b1001, 1'b1, 2'd3);
    exp_q.push_back(mkf(C0, C0, C0, C0, 4'b1001, 4'b1110, 2'd3));
    release_reset();
    wait_done();

    // Reset during digit 2 slot 9, restart with a fresh snapshot
    begin_reset(16'h1234, 4'b0000, 1'b0, 2'd3);
    exp_q.push_back(mkf(C1, C2, C3, C4, 4'b0000, 4'b0000, 2'd3));
    release_reset();
    wait_fs();
    repeat (2 * DC + 9) @(posedge clk);
    #2;
    rst        = 1'b1;
    dif.bcd_in = 16'h5678;
    @(posedge clk);
    #1;
    exp_q.push_back(mkf(C5, C6, C7, C8, 4'b0000, 4'b0000, 2'd3));
    release_reset();
    wait_done();

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_seven_seg_scan_driver.md
PARAM_SEVEN_SEG_SCAN_DRIVER -- requirements
Module: param_seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal 2..8.
REQ-002 SHALL have parameter DIGIT_CYCLES, default 1024: clocks per digit slot; power of two, >= 2^BRIGHT_W.
REQ-003 SHALL have parameter BRIGHT_W, default 4: brightness control width.
REQ-004 SHALL have port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port bcd_in  input  4*NUM_DIGITS  BCD digits; digit i = bcd_in[4i+3:4i], digit 0 least significant.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-009 SHALL have port brightness  input  BRIGHT_W  duty level; 0 = dark, 2^BRIGHT_W-1 = brightest.
REQ-010 SHALL have port seg_anode  output  NUM_DIGITS  digit enables, active-low; bit i drives digit i.
REQ-011 SHALL have port seg_cathode  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port seg_dp  output  1  decimal point segment, active-low.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when a new snapshot is captured.

Function
REQ-014 SHALL run a slot counter 0..DIGIT_CYCLES-1, wrapping to 0; at wrap, digit index advances 0,1,..,NUM_DIGITS-1,0.
REQ-015 SHALL capture bcd_in, dp_in, blank_lz, brightness into a snapshot register on the first cycle after rst deasserts and whenever the digit index wraps NUM_DIGITS-1 -> 0; display uses only the snapshot, never live inputs.
REQ-016 SHALL pulse frame_start high for exactly the cycle in which the snapshot is captured.
REQ-017 SHALL decode snapshot digits 0-9 active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 SHALL display codes 10-15 (invalid BCD) as dash, cathode 0111111.
REQ-019 SHALL, with snapshot blank_lz=1, blank digit i (i>=1) when digit i and all digits above it are 0; digit 0 never blanked.
REQ-020 SHALL, for a blanked digit, hold its anode at 1 and cathode/dp at all-ones for the entire slot, including dp requests.
REQ-021 SHALL split each slot into 2^BRIGHT_W equal sub-slots, sub = slot_count / (DIGIT_CYCLES >> BRIGHT_W); anode of the current digit low only while sub < snapshot brightness.
REQ-022 SHALL hold all anodes at 1 and cathode 1111111, seg_dp 1 whenever the current digit is dark (PWM off or blanked).
REQ-023 SHALL assert at most one anode low in any cycle; all other anodes 1.
REQ-024 SHALL register all outputs; outputs in cycle n+1 reflect slot counter, digit index and snapshot of cycle n (one-cycle latency).
REQ-025 SHALL drive seg_dp low when the current digit is lit and its snapshot dp bit is 1.

Reset
REQ-026 SHALL, while rst=1: seg_anode all 1, seg_cathode 1111111, seg_dp 1, frame_start 0, slot counter 0, digit index 0, snapshot 0.
REQ-027 SHALL, on rst asserted mid-slot or mid-frame, abandon the scan and restart at digit 0, slot count 0, with fresh snapshot per REQ-015.

Verification (NUM_DIGITS=4, DIGIT_CYCLES=16, BRIGHT_W=2, sub-slot = 4 clocks)
REQ-028 SHALL: rst 3 cycles, bcd_in=16'h1234, brightness=3, dp_in=0, blank_lz=0 -> frame_start pulse 1st cycle after reset; digit 0 anode 1110, cathode 0011001 ("4") for 12 cycles, dark 4; then 1101 "3", 1011 "2", 0111 "1"; frame_start every 64 cycles.
REQ-029 SHALL: bcd_in=16'h0070, blank_lz=1 -> digits 3,2 anodes never low; digit 1 shows "7" 1111000; digit 0 shows "0" 1000000; blank_lz=0 -> digits 3,2 show "0".
REQ-030 SHALL: change bcd_in 16'h1234 -> 16'h5678 mid-frame -> displayed values stay 1234 until next frame_start, then 5678.
REQ-031 SHALL: brightness=0 -> all anodes 1 every cycle; brightness=1 -> each anode low 4 of 16 slot cycles.
REQ-032 SHALL: bcd_in=16'hAF09, dp_in=4'b0100 -> digit 3,2 show dash 0111111, seg_dp low only during digit 2 lit cycles; digit 0 "9".
REQ-033 SHALL: assert rst during digit 2 slot count 9 -> next cycle all outputs at reset values; after release scan restarts at digit 0 slot 0 with frame_start pulse.
